// File: rtl/satd_diff_seq.sv
// Fetches an N x N pixel block, captures the org-cur differences and streams them out in raster order.
// N=4 by default; define SATD_8X8_EN for an 8x8 block.
module satd_diff_seq #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        org_data,
  input  logic [7:0]        cur_data,
  output logic              diff_en,
  input  logic [8:0]        diff_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8:0]        out_diff,
  output logic [5:0]        out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

`ifdef SATD_8X8_EN
  localparam int N = 8;
`else
  localparam int N = 4;
`endif
  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam int CW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] row_addr;
  logic [ADDR_W-1:0] stride_q;
  logic [IW-1:0]     fidx;
  logic [CW-1:0]     col;
  logic [IW-1:0]     p1_idx, p2_idx;
  logic              p2_vld;
  logic [IW-1:0]     rd_idx;
  logic [8:0]        buffer [NN];

  // The pixel data is not used here; the external difference unit consumes it.
  logic unused_ok;
  assign unused_ok = ^{org_data, cur_data};

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign out_idx  = 6'(rd_idx);
  assign out_last = out_valid && (rd_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: if (fidx == LAST_IDX) state_nxt = S_DRAIN;
      S_DRAIN: if (p2_vld && p2_idx == LAST_IDX) state_nxt = S_OUT;
      S_OUT:   if (out_valid && out_ready && out_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      row_addr  <= '0;
      stride_q  <= '0;
      fidx      <= '0;
      col       <= '0;
      diff_en   <= 1'b0;
      p1_idx    <= '0;
      p2_vld    <= 1'b0;
      p2_idx    <= '0;
      out_valid <= 1'b0;
      out_diff  <= '0;
      rd_idx    <= '0;
    end else begin
      // diff_en doubles as the first capture stage valid.
      diff_en <= mem_rd;
      p1_idx  <= fidx;
      p2_vld  <= diff_en;
      p2_idx  <= p1_idx;
      case (state)
        S_IDLE: if (start) begin
          mem_rd   <= 1'b1;
          mem_addr <= base_addr;
          row_addr <= base_addr;
          stride_q <= stride;
          fidx     <= '0;
          col      <= '0;
        end
        S_FETCH: if (fidx == LAST_IDX) begin
          mem_rd <= 1'b0;
        end else begin
          fidx <= fidx + 1'b1;
          if (col == LAST_COL) begin
            col      <= '0;
            row_addr <= row_addr + stride_q;
            mem_addr <= row_addr + stride_q;
          end else begin
            col      <= col + 1'b1;
            mem_addr <= mem_addr + 1'b1;
          end
        end
        // First OUT cycle loads sample 0 from the buffer; then advance on each handshake.
        S_OUT: if (!out_valid) begin
          out_valid <= 1'b1;
          rd_idx    <= '0;
          out_diff  <= buffer[0];
        end else if (out_ready) begin
          if (out_last) begin
            out_valid <= 1'b0;
          end else begin
            rd_idx   <= rd_idx + 1'b1;
            out_diff <= buffer[rd_idx + 1'b1];
          end
        end
        S_DONE: rd_idx <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (p2_vld) buffer[p2_idx] <= diff_in;
  end

endmodule

// File: tb/tb_satd_diff_seq.sv
// Bench for satd_diff_seq: pixel memories and difference unit modelled here, outputs checked against a raster-order model.
module tb_satd_diff_seq;

`ifdef SATD_8X8_EN
  localparam int N = 8;
`else
  localparam int N = 4;
`endif
  localparam int NN = N * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0, stride = '0;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [7:0]  org_data = '0, cur_data = '0;
  logic        diff_en;
  logic [8:0]  diff_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [8:0]  out_diff;
  logic [5:0]  out_idx;
  logic        out_last, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  satd_diff_seq #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .org_data(org_data), .cur_data(cur_data),
    .diff_en(diff_en), .diff_in(diff_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  // Pixel memories (one-cycle read) and registered difference unit.
  logic [7:0] org_mem [0:4095];
  logic [7:0] cur_mem [0:4095];
  always @(posedge clk) begin
    if (mem_rd) begin
      org_data <= org_mem[mem_addr];
      cur_data <= cur_mem[mem_addr];
    end
    if (diff_en) diff_in <= {1'b0, org_data} - {1'b0, cur_data};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [11:0] m_base = '0, m_stride = '0;

  function automatic logic [11:0] exp_addr(input int k);
    logic [31:0] a;
    a = 32'(m_base) + 32'((k / N) * int'(m_stride)) + 32'(k % N);
    return a[11:0];
  endfunction

  function automatic logic [8:0] exp_diff(input int k);
    logic [11:0] a;
    a = exp_addr(k);
    return {1'b0, org_mem[a]} - {1'b0, cur_mem[a]};
  endfunction

  // Compare process: every cycle, against the block model.
  int rd_cnt = 0, smp_cnt = 0;
  bit done_due = 0, prev_vld = 0, prev_fin = 0, busy_low_due = 0;
  logic [11:0] addr_q [$];

  always @(negedge clk) begin
    if (rst) begin
      rd_cnt = 0; smp_cnt = 0; done_due = 0; prev_vld = 0; prev_fin = 0; busy_low_due = 0;
    end else begin
      chk("done", done, done_due);
      if (busy_low_due) chk("busy_after_done", busy, 0);
      busy_low_due = done_due;
      if (prev_vld && !prev_fin) chk("valid_hold", out_valid, 1);
      if (mem_rd) begin
        chk("read_count", rd_cnt < NN, 1);
        chk("mem_addr", mem_addr, exp_addr(rd_cnt));
        addr_q.push_back(mem_addr);
        rd_cnt++;
      end
      if (out_valid) begin
        chk("out_idx", out_idx, smp_cnt);
        chk("out_diff", out_diff, exp_diff(smp_cnt));
        chk("out_last", out_last, smp_cnt == NN - 1);
      end
      done_due = out_valid && out_ready && (smp_cnt == NN - 1);
      prev_vld = out_valid;
      prev_fin = done_due;
      if (out_valid && out_ready) smp_cnt++;
      if (start && !busy) begin
        rd_cnt = 0; smp_cnt = 0; m_base = base_addr; m_stride = stride; addr_q.delete();
      end
    end
  end

  task automatic fill_const(input logic [7:0] o, input logic [7:0] c);
    for (int a = 0; a < 4096; a++) begin org_mem[a] = o; cur_mem[a] = c; end
  endtask

  task automatic fill_pattern();
    for (int a = 0; a < 4096; a++) begin org_mem[a] = 8'(a * 7); cur_mem[a] = 8'(a * 13); end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_diff_en"}, diff_en, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_out_diff"}, out_diff, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
  endtask

  task automatic run_block(input logic [11:0] b, input logic [11:0] s, input int stall_idx,
                           input int stall_len, input bit ign, input logic [8:0] first_exp);
    int lat, guard;
    bit stalled, pulsed;
    @(posedge clk); #1;
    base_addr = b; stride = s; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, NN + 3);
    chk("first_diff", out_diff, first_exp);
    guard = 0; stalled = 0; pulsed = 0;
    while (!done && guard < 1000) begin
      if (stall_len > 0 && !stalled && out_valid && out_idx == 6'(stall_idx)) begin
        out_ready = 1'b0;
        repeat (stall_len) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        stalled = 1;
      end else if (ign && !pulsed && out_valid && out_idx == 6'd1) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulsed = 1;
      end else begin
        @(posedge clk); #1;
      end
      guard++;
    end
    chk("done_seen", done, 1);
    if (ign) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_idle_after_done", busy, 0);
      repeat (4) begin
        @(posedge clk); #1;
        chk("ignored_start_no_read", mem_rd, 0);
        chk("ignored_start_idle", busy, 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    fill_const(8'd200, 8'd50);
    run_block(12'd100, 12'd64, -1, 0, 0, 9'h096);
    chk("addr_count", addr_q.size(), NN);
    chk("addr_first", addr_q[0], 100);
    chk("addr_row1", addr_q[N], 164);
    chk("addr_row2", addr_q[2 * N], 228);
    chk("addr_last", addr_q[NN - 1], (N == 4) ? 295 : 555);

    fill_const(8'd0, 8'd255);
    run_block(12'd7, 12'd32, -1, 0, 0, 9'h101);
    fill_const(8'd255, 8'd0);
    run_block(12'd300, 12'd40, -1, 0, 0, 9'h0FF);

    // Varying data, address wrap past 4095, stall on sample 3.
    fill_pattern();
    run_block(12'd4090, 12'd100, 3, 5, 0, 9'h024);

    // Reset while fetching sample 7.
    @(posedge clk); #1;
    base_addr = 12'd20; stride = 12'd16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    chk("addr_at_idx7", mem_addr, (N == 4) ? 39 : 27);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero("mid_reset");
    repeat (NN + 8) begin
      @(posedge clk); #1;
      chk("abandoned_no_valid", out_valid, 0);
    end

    run_block(12'd500, 12'd3, -1, 0, 1, 9'h048);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
